// File: rtl/vector_alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vector_alu_seq : LANES x DATA_W vector ALU, valid/ready in and out,
//                  element-wise ops in one cycle, reductions one lane/cycle.
// Revision: 1.0
// ---------------------------------------------------------------------------
module vector_alu_seq #(
  parameter int    LANES  = 4,
  parameter int    DATA_W = 32,
  localparam int   IDX_W  = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                op,
  input  logic [LANES*IDX_W-1:0]    imm,
  input  logic [LANES*DATA_W-1:0]   v1,
  input  logic [LANES*DATA_W-1:0]   v2,
  input  logic [DATA_W-1:0]         r1,
  input  logic [DATA_W-1:0]         r2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   vout,
  output logic [DATA_W-1:0]         rout,
  output logic                      err
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_EXEC = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  localparam logic [4:0] c_OP_VADD     = 5'h03;
  localparam logic [4:0] c_OP_VSUB     = 5'h04;
  localparam logic [4:0] c_OP_VMULT    = 5'h05;
  localparam logic [4:0] c_OP_VDOT     = 5'h06;
  localparam logic [4:0] c_OP_VDOTA    = 5'h07;
  localparam logic [4:0] c_OP_VINDX    = 5'h08;
  localparam logic [4:0] c_OP_VREDUCE  = 5'h09;
  localparam logic [4:0] c_OP_VSPLAT   = 5'h0A;
  localparam logic [4:0] c_OP_VSWIZZLE = 5'h0B;
  localparam logic [4:0] c_OP_VSADD    = 5'h0C;
  localparam logic [4:0] c_OP_VSSUB    = 5'h0D;
  localparam logic [4:0] c_OP_VSMULT   = 5'h0E;
  localparam logic [4:0] c_OP_VSMA     = 5'h0F;
  localparam logic [4:0] c_OP_VCOMPSEL = 5'h10;
  localparam logic [4:0] c_OP_VMAX     = 5'h11;
  localparam logic [4:0] c_OP_VMIN     = 5'h12;

  localparam logic [IDX_W-1:0] c_LAST_LANE = IDX_W'(LANES - 1);

  logic [1:0]              r_state;
  logic [4:0]              r_op;
  logic [LANES*IDX_W-1:0]  r_imm;
  logic [LANES*DATA_W-1:0] r_v1;
  logic [LANES*DATA_W-1:0] r_v2;
  logic [DATA_W-1:0]       r_r1;
  logic [DATA_W-1:0]       r_r2;
  logic [DATA_W-1:0]       r_acc;
  logic [IDX_W-1:0]        r_cnt;
  logic [LANES*DATA_W-1:0] r_vout;
  logic [DATA_W-1:0]       r_rout;
  logic                    r_err;

  logic [DATA_W-1:0]       w_a [LANES];
  logic [DATA_W-1:0]       w_b [LANES];
  logic [LANES*DATA_W-1:0] w_vres;
  logic [DATA_W-1:0]       w_rres;
  logic                    w_err;
  logic                    w_is_red;
  logic [DATA_W-1:0]       w_term;

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_unpack
      assign w_a[g] = r_v1[g*DATA_W +: DATA_W];
      assign w_b[g] = r_v2[g*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_is_red = (r_op == c_OP_VDOT) || (r_op == c_OP_VDOTA) || (r_op == c_OP_VREDUCE);

  // Shared reduction datapath: one lane contribution per EXEC cycle.
  assign w_term = (r_op == c_OP_VREDUCE) ? w_a[r_cnt] : w_a[r_cnt] * w_b[r_cnt];

  always_comb begin
    w_vres = '0;
    w_rres = '0;
    w_err  = 1'b0;
    case (r_op)
      c_OP_VINDX: w_rres = w_a[r_imm[IDX_W-1:0]];
      c_OP_VADD, c_OP_VSUB, c_OP_VMULT, c_OP_VDOT, c_OP_VDOTA, c_OP_VREDUCE,
      c_OP_VSPLAT, c_OP_VSWIZZLE, c_OP_VSADD, c_OP_VSSUB, c_OP_VSMULT,
      c_OP_VSMA, c_OP_VCOMPSEL, c_OP_VMAX, c_OP_VMIN: begin
      end
      default: w_err = 1'b1;
    endcase
    for (int i = 0; i < LANES; i++) begin
      case (r_op)
        c_OP_VADD:     w_vres[i*DATA_W +: DATA_W] = w_a[i] + w_b[i];
        c_OP_VSUB:     w_vres[i*DATA_W +: DATA_W] = w_a[i] - w_b[i];
        c_OP_VMULT:    w_vres[i*DATA_W +: DATA_W] = w_a[i] * w_b[i];
        c_OP_VSPLAT:   w_vres[i*DATA_W +: DATA_W] = r_r1;
        c_OP_VSWIZZLE: w_vres[i*DATA_W +: DATA_W] = w_a[r_imm[i*IDX_W +: IDX_W]];
        c_OP_VSADD:    w_vres[i*DATA_W +: DATA_W] = w_a[i] + r_r1;
        c_OP_VSSUB:    w_vres[i*DATA_W +: DATA_W] = w_a[i] - r_r1;
        c_OP_VSMULT:   w_vres[i*DATA_W +: DATA_W] = w_a[i] * r_r1;
        c_OP_VSMA:     w_vres[i*DATA_W +: DATA_W] = w_a[i] * r_r1 + w_b[i];
        c_OP_VCOMPSEL: w_vres[i*DATA_W +: DATA_W] =
                         ($signed(w_a[i]) > $signed(w_b[i])) ? r_r1 : r_r2;
        c_OP_VMAX:     w_vres[i*DATA_W +: DATA_W] =
                         ($signed(w_a[i]) > $signed(w_b[i])) ? w_a[i] : w_b[i];
        c_OP_VMIN:     w_vres[i*DATA_W +: DATA_W] =
                         ($signed(w_a[i]) < $signed(w_b[i])) ? w_a[i] : w_b[i];
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_op    <= '0;
      r_imm   <= '0;
      r_v1    <= '0;
      r_v2    <= '0;
      r_r1    <= '0;
      r_r2    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_vout  <= '0;
      r_rout  <= '0;
      r_err   <= 1'b0;
    end else if (en) begin
      case (r_state)
        c_ST_IDLE: begin
          if (in_valid) begin
            r_op    <= op;
            r_imm   <= imm;
            r_v1    <= v1;
            r_v2    <= v2;
            r_r1    <= r1;
            r_r2    <= r2;
            r_acc   <= (op == c_OP_VDOTA) ? r2 : '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_state <= c_ST_EXEC;
          end
        end
        c_ST_EXEC: begin
          if (w_is_red) begin
            r_acc <= r_acc + w_term;
            if (r_cnt == c_LAST_LANE) begin
              r_rout  <= r_acc + w_term;
              r_vout  <= '0;
              r_err   <= 1'b0;
              r_cnt   <= '0;
              r_state <= c_ST_DONE;
            end else begin
              r_cnt <= r_cnt + IDX_W'(1);
            end
          end else begin
            r_vout  <= w_vres;
            r_rout  <= w_rres;
            r_err   <= w_err;
            r_state <= c_ST_DONE;
          end
        end
        c_ST_DONE: begin
          if (out_ready) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == c_ST_IDLE);
  assign out_valid = (r_state == c_ST_DONE);
  assign vout      = r_vout;
  assign rout      = r_rout;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vector_alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vector_alu_seq : directed + random stimulus against a lane-level model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_vector_alu_seq;

  localparam int LANES  = 4;
  localparam int DATA_W = 32;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [7:0]   imm;
  logic [127:0] v1;
  logic [127:0] v2;
  logic [31:0]  r1;
  logic [31:0]  r2;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] vout;
  logic [31:0]  rout;
  logic         err;

  int n_checks;
  int n_pass;

  vector_alu_seq #(.LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .imm(imm), .v1(v1), .v2(v2), .r1(r1), .r2(r2),
    .out_valid(out_valid), .out_ready(out_ready),
    .vout(vout), .rout(rout), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  // Reference: lane arrays and plain arithmetic, truncated to 32 bits.
  task automatic model(input logic [4:0] m_op, input logic [7:0] m_imm,
                       input logic [127:0] m_v1, m_v2, input logic [31:0] m_r1, m_r2,
                       output logic [127:0] ev, output logic [31:0] er,
                       output logic ee, output int lat);
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] res [4];
    logic [31:0] sum;
    for (int i = 0; i < 4; i++) begin
      a[i] = m_v1[i*32 +: 32];
      b[i] = m_v2[i*32 +: 32];
      res[i] = 32'h0;
    end
    er = 32'h0;
    ee = 1'b0;
    sum = 32'h0;
    lat = 2;
    case (m_op)
      5'h03: for (int i = 0; i < 4; i++) res[i] = a[i] + b[i];
      5'h04: for (int i = 0; i < 4; i++) res[i] = a[i] - b[i];
      5'h05: for (int i = 0; i < 4; i++) res[i] = a[i] * b[i];
      5'h06: begin for (int i = 0; i < 4; i++) sum += a[i] * b[i]; er = sum; lat = 5; end
      5'h07: begin for (int i = 0; i < 4; i++) sum += a[i] * b[i]; er = m_r2 + sum; lat = 5; end
      5'h08: er = a[m_imm[1:0]];
      5'h09: begin for (int i = 0; i < 4; i++) sum += a[i]; er = sum; lat = 5; end
      5'h0A: for (int i = 0; i < 4; i++) res[i] = m_r1;
      5'h0B: for (int i = 0; i < 4; i++) res[i] = a[m_imm[i*2 +: 2]];
      5'h0C: for (int i = 0; i < 4; i++) res[i] = a[i] + m_r1;
      5'h0D: for (int i = 0; i < 4; i++) res[i] = a[i] - m_r1;
      5'h0E: for (int i = 0; i < 4; i++) res[i] = a[i] * m_r1;
      5'h0F: for (int i = 0; i < 4; i++) res[i] = a[i] * m_r1 + b[i];
      5'h10: for (int i = 0; i < 4; i++) res[i] = ($signed(a[i]) > $signed(b[i])) ? m_r1 : m_r2;
      5'h11: for (int i = 0; i < 4; i++) res[i] = ($signed(a[i]) > $signed(b[i])) ? a[i] : b[i];
      5'h12: for (int i = 0; i < 4; i++) res[i] = ($signed(a[i]) < $signed(b[i])) ? a[i] : b[i];
      default: ee = 1'b1;
    endcase
    ev = {res[3], res[2], res[1], res[0]};
  endtask

  // Called at a negedge; returns just after the acceptance posedge.
  task automatic accept(input logic [4:0] a_op, input logic [7:0] a_imm,
                        input logic [127:0] a_v1, a_v2, input logic [31:0] a_r1, a_r2);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("ready_timeout", 0, 1);
    in_valid = 1'b1;
    op = a_op; imm = a_imm; v1 = a_v1; v2 = a_v2; r1 = a_r1; r2 = a_r2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 5'($urandom); imm = 8'($urandom);
    v1 = {$urandom, $urandom, $urandom, $urandom};
    v2 = {$urandom, $urandom, $urandom, $urandom};
    r1 = $urandom; r2 = $urandom;
  endtask

  task automatic run_op(input string name, input logic [4:0] t_op, input logic [7:0] t_imm,
                        input logic [127:0] t_v1, t_v2, input logic [31:0] t_r1, t_r2,
                        input int hold, input int gap);
    logic [127:0] ev;
    logic [31:0]  er;
    logic         ee;
    int           exp_lat;
    int           lat;
    logic         ready_bad;
    model(t_op, t_imm, t_v1, t_v2, t_r1, t_r2, ev, er, ee, exp_lat);
    exp_lat += gap;
    out_ready = (hold == 0);
    accept(t_op, t_imm, t_v1, t_v2, t_r1, t_r2);
    lat = 1;
    ready_bad = 1'b0;
    @(negedge clk);
    if (gap > 0) begin
      en = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        lat++;
      end
      @(negedge clk);
      en = 1'b1;
    end
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_bad = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_rdy_exec"}, ready_bad, 0);
    check({name, "_vout"}, vout, ev);
    check({name, "_rout"}, rout, er);
    check({name, "_err"}, err, ee);
    check({name, "_rdy_done"}, in_ready, 0);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
      end
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_vout"}, vout, ev);
      check({name, "_hold_rout"}, rout, er);
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check({name, "_drain_valid"}, out_valid, 0);
    check({name, "_drain_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [4:0] rop;
    n_checks = 0;
    n_pass = 0;
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; imm = '0; v1 = '0; v2 = '0; r1 = '0; r2 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_vout", vout, 0);
    check("rst_rout", rout, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("vadd", 5'h03, 8'h00, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 0, 0, 0, 0);
    check("vadd_known", vout, pack4(11, 22, 33, 44));
    run_op("vdota", 5'h07, 8'h00, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 0, 100, 0, 0);
    check("vdota_known", rout, 170);
    run_op("swz", 5'h0B, 8'b00_01_10_11, pack4(32'hA, 32'hB, 32'hC, 32'hD), '0, 0, 0, 0, 0);
    check("swz_known", vout, pack4(32'hD, 32'hC, 32'hB, 32'hA));
    run_op("vindx", 5'h08, 8'h02, pack4(32'hA, 32'hB, 32'hC, 32'hD), '0, 0, 0, 0, 0);
    check("vindx_known", rout, 32'hC);
    run_op("vmax", 5'h11, 8'h00, pack4(32'hFFFFFFFF, 5, 0, 32'h7FFFFFFF),
           pack4(0, 4, 0, 32'h80000000), 0, 0, 5, 0);
    check("vmax_known", vout, pack4(0, 5, 0, 32'h7FFFFFFF));

    // Reset during the third EXEC cycle of a reduction.
    accept(5'h09, 8'h00, pack4(7, 7, 7, 7), '0, 0, 0);
    @(negedge clk);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #2;
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_rout", rout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("postrst_valid", out_valid, 0);
    check("postrst_ready", in_ready, 1);

    run_op("vred1", 5'h09, 8'h00, pack4(1, 1, 1, 1), '0, 0, 0, 0, 0);
    check("vred1_known", rout, 4);
    run_op("vmulwrap", 5'h05, 8'h00, pack4(32'h10000, 32'h10000, 32'h10000, 32'h10000),
           pack4(32'h10000, 32'h10000, 32'h10000, 32'h10000), 0, 0, 0, 0);
    check("vmulwrap_known", vout, 0);
    run_op("illegal", 5'h1F, 8'h00, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 0, 0, 0, 0);
    run_op("illegal_gap", 5'h1F, 8'h00, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 0, 0, 0, 3);
    run_op("vdot_gap", 5'h06, 8'h00, pack4(2, 3, 4, 5), pack4(6, 7, 8, 9), 0, 0, 0, 3);
    run_op("errclear", 5'h0C, 8'h00, pack4(1, 2, 3, 4), '0, 5, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) rop = 5'($urandom);
      else rop = 5'($urandom_range(3, 18));
      run_op("rand", rop, 8'($urandom),
             {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom},
             $urandom, $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
             ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
